// File: rtl/riscv_types.sv
// Core-wide RISC-V execute types shared by the execute-stage units.
// alu_t encodes the ALU/M-extension operation; the bus carries writeback sideband.
package riscv_types;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_we;
    logic [1:0]  wb_sel;
  } exe_p_mux_bus_type;

endpackage

// File: rtl/int_mul_pipe_prod.sv
// Signed WxW -> 2W combinational multiplier core; kept standalone so a
// technology multiplier macro can be dropped in without touching the pipeline.
module int_mul_prod #(
  parameter int W = 33
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] prod
);

  assign prod = a * b;

endmodule

// File: rtl/int_mul_pipe.sv
// RISC-V M-extension multiply unit: fixed-latency STAGES-deep pipeline with
// flush, enable-stall, occupancy and destination-register hazard reporting.
module int_mul_pipe
  import riscv_types::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              p_start,
  input  exe_p_mux_bus_type i_pipelined_signals,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  alu_t              alu_op,
  input  logic [4:0]        chk_rd,
  output exe_p_mux_bus_type o_pipelined_signals,
  output logic [4:0]        uu_rd,
  output logic              p_last,
  output logic [XLEN-1:0]   result,
  output logic              busy,
  output logic              rd_hit
);

  localparam int PW = 2*XLEN + 2;

  function automatic logic is_mul_op(input alu_t op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic rs1_signed(input alu_t op);
    return op inside {MUL, MULH, MULHSU};
  endfunction

  function automatic logic rs2_signed(input alu_t op);
    return op inside {MUL, MULH};
  endfunction

  function automatic logic signed [XLEN:0] ext_operand(input logic [XLEN-1:0] x,
                                                       input logic sgn);
    return sgn ? {x[XLEN-1], x} : {1'b0, x};
  endfunction

  // Unsupported opcodes still flow down the pipe but retire a zero result.
  function automatic logic [XLEN-1:0] sel_result(input alu_t op,
                                                 input logic signed [PW-1:0] prod);
    if (!is_mul_op(op))
      return '0;
    if (op == MUL)
      return prod[XLEN-1:0];
    return prod[2*XLEN-1:XLEN];
  endfunction

  logic signed [XLEN:0] mul_a;
  logic signed [XLEN:0] mul_b;
  logic signed [PW-1:0] mul_prod;
  alu_t                 mul_op;
  logic [XLEN-1:0]      mul_res;
  logic                 adv;

  assign adv = en && !flush;

  int_mul_prod #(.W(XLEN+1)) u_prod (
    .a    (mul_a),
    .b    (mul_b),
    .prod (mul_prod)
  );

  assign mul_res = sel_result(mul_op, mul_prod);
  assign uu_rd   = o_pipelined_signals.rd;

  generate
    if (STAGES == 1) begin : g_single
      // Stage 1: multiply straight off the inputs into the output register
      assign mul_op = alu_op;
      assign mul_a  = ext_operand(rs1, rs1_signed(alu_op));
      assign mul_b  = ext_operand(rs2, rs2_signed(alu_op));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          p_last              <= 1'b0;
          result              <= '0;
          o_pipelined_signals <= '0;
        end else begin
          if (flush)
            p_last <= 1'b0;
          else if (en)
            p_last <= p_start;
          if (adv && p_start) begin
            result              <= mul_res;
            o_pipelined_signals <= i_pipelined_signals;
          end
        end
      end

      assign busy   = 1'b0;
      assign rd_hit = p_last && (chk_rd != '0) && (o_pipelined_signals.rd == chk_rd);

    end else begin : g_multi
      logic              vld_p1;
      logic [XLEN-1:0]   rs1_p1;
      logic [XLEN-1:0]   rs2_p1;
      alu_t              op_p1;
      exe_p_mux_bus_type sb_p1;

      logic              vld_pn [2:STAGES];
      logic [XLEN-1:0]   res_pn [2:STAGES];
      exe_p_mux_bus_type sb_pn  [2:STAGES];

      logic              busy_or;
      logic              any_hit;

      // Stage 1: operand, opcode and sideband capture
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p1 <= 1'b0;
          rs1_p1 <= '0;
          rs2_p1 <= '0;
          op_p1  <= alu_t'(0);
          sb_p1  <= '0;
        end else begin
          if (flush)
            vld_p1 <= 1'b0;
          else if (en)
            vld_p1 <= p_start;
          if (adv && p_start) begin
            rs1_p1 <= rs1;
            rs2_p1 <= rs2;
            op_p1  <= alu_op;
            sb_p1  <= i_pipelined_signals;
          end
        end
      end

      assign mul_op = op_p1;
      assign mul_a  = ext_operand(rs1_p1, rs1_signed(op_p1));
      assign mul_b  = ext_operand(rs2_p1, rs2_signed(op_p1));

      // Stages 2..STAGES: product retiming chain; the last stage is the output
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 2; s <= STAGES; s++) begin
            vld_pn[s] <= 1'b0;
            res_pn[s] <= '0;
            sb_pn[s]  <= '0;
          end
        end else begin
          if (flush) begin
            for (int s = 2; s <= STAGES; s++)
              vld_pn[s] <= 1'b0;
          end else if (en) begin
            vld_pn[2] <= vld_p1;
            for (int s = 3; s <= STAGES; s++)
              vld_pn[s] <= vld_pn[s-1];
          end
          if (adv && vld_p1) begin
            res_pn[2] <= mul_res;
            sb_pn[2]  <= sb_p1;
          end
          for (int s = 3; s <= STAGES; s++) begin
            if (adv && vld_pn[s-1]) begin
              res_pn[s] <= res_pn[s-1];
              sb_pn[s]  <= sb_pn[s-1];
            end
          end
        end
      end

      // busy ignores the output stage; the hazard check includes it.
      always_comb begin
        busy_or = vld_p1;
        for (int s = 2; s < STAGES; s++)
          busy_or = busy_or | vld_pn[s];
      end

      always_comb begin
        any_hit = vld_p1 && (sb_p1.rd == chk_rd);
        for (int s = 2; s <= STAGES; s++)
          any_hit = any_hit | (vld_pn[s] && (sb_pn[s].rd == chk_rd));
      end

      assign busy                = busy_or;
      assign rd_hit              = any_hit && (chk_rd != '0);
      assign p_last              = vld_pn[STAGES];
      assign result              = res_pn[STAGES];
      assign o_pipelined_signals = sb_pn[STAGES];
    end
  endgenerate

endmodule

// File: tb/tb_int_mul_pipe.sv
// Directed and randomised stimulus for int_mul_pipe with a timed scoreboard.
module tb_int_mul_pipe;
  import riscv_types::*;

  localparam int XLEN   = 32;
  localparam int STAGES = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic              p_start = 1'b0;
  exe_p_mux_bus_type i_sig = '0;
  exe_p_mux_bus_type o_sig;
  logic [XLEN-1:0]   rs1 = '0;
  logic [XLEN-1:0]   rs2 = '0;
  alu_t              alu_op = ADD;
  logic [4:0]        chk_rd = '0;
  logic [4:0]        uu_rd;
  logic              p_last;
  logic [XLEN-1:0]   result;
  logic              busy;
  logic              rd_hit;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  typedef struct {
    int                due;
    logic [31:0]       res;
    exe_p_mux_bus_type sb;
  } exp_t;

  exp_t              q[$];
  logic              exp_plast = 1'b0;
  logic [31:0]       last_res = '0;
  exe_p_mux_bus_type last_sb = '0;
  alu_t              op_pool[6] = '{MUL, MULH, MULHSU, MULHU, ADD, REM};

  always #5 clk = ~clk;

  int_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .en                  (en),
    .flush               (flush),
    .p_start             (p_start),
    .i_pipelined_signals (i_sig),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .alu_op              (alu_op),
    .chk_rd              (chk_rd),
    .o_pipelined_signals (o_sig),
    .uu_rd               (uu_rd),
    .p_last              (p_last),
    .result              (result),
    .busy                (busy),
    .rd_hit              (rd_hit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input alu_t o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb_ext;
    longint      ub;
    logic [63:0] p;
    sa     = longint'($signed(a));
    sb_ext = longint'($signed(b));
    ub     = longint'({32'b0, b});
    case (o)
      MUL:     begin p = sa * sb_ext; return p[31:0]; end
      MULH:    begin p = sa * sb_ext; return p[63:32]; end
      MULHSU:  begin p = sa * ub; return p[63:32]; end
      MULHU:   begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (flush) begin
      q.delete();
      exp_plast = 1'b0;
      chk("flush_p_last", p_last, 0);
      chk("flush_busy", busy, 0);
    end else if (en) begin
      ecnt++;
      if (q.size() > 0 && q[0].due == ecnt) begin
        e = q.pop_front();
        chk("p_last", p_last, 1);
        chk("result", result, e.res);
        chk("uu_rd", uu_rd, e.sb.rd);
        chk("o_pipelined_signals", o_sig, e.sb);
        exp_plast = 1'b1;
        last_res  = e.res;
        last_sb   = e.sb;
      end else begin
        exp_plast = 1'b0;
        chk("p_last_idle", p_last, 0);
        chk("result_hold", result, last_res);
        chk("o_sig_hold", o_sig, last_sb);
      end
    end else begin
      chk("stall_p_last", p_last, exp_plast);
      chk("stall_result", result, last_res);
      chk("stall_uu_rd", uu_rd, last_sb.rd);
    end
  endtask

  task automatic op(input alu_t o, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input logic [31:0] expv);
    p_start       = 1'b1;
    alu_op        = o;
    rs1           = a;
    rs2           = b;
    i_sig.pc      = $urandom;
    i_sig.rd      = rd;
    i_sig.rf_we   = 1'b1;
    i_sig.wb_sel  = 2'($urandom_range(0, 3));
    if (en && !flush && reset_n)
      q.push_back('{ecnt + STAGES, expv, i_sig});
    tick();
  endtask

  task automatic mop(input alu_t o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd);
    op(o, a, b, rd, model(o, a, b));
  endtask

  task automatic idle(input int n);
    p_start = 1'b0;
    for (int i = 0; i < n; i++)
      tick();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    alu_t        ro;

    // reset state
    chk_rd = 5'd5;
    #1;
    chk("rst_p_last", p_last, 0);
    chk("rst_result", result, 0);
    chk("rst_uu_rd", uu_rd, 0);
    chk("rst_o_sig", o_sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_hit", rd_hit, 0);
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    chk_rd  = '0;

    // signed corner products and latency
    op(MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    chk("busy_after_accept", busy, 1);
    op(MUL, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h0000_0000);
    idle(4);
    op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
    op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd8, 32'hFFFF_FFEB);
    idle(4);

    // back-to-back with hazard query
    mop(MUL, 32'd100, 32'd200, 5'd5);
    mop(MULH, 32'hDEAD_BEEF, 32'h1234_5678, 5'd6);
    chk_rd = 5'd6;
    #1 chk("rd_hit_6", rd_hit, 1);
    chk_rd = 5'd5;
    #1 chk("rd_hit_5", rd_hit, 1);
    chk_rd = 5'd9;
    #1 chk("rd_hit_miss", rd_hit, 0);
    chk_rd = 5'd0;
    #1 chk("rd_hit_x0", rd_hit, 0);
    mop(MULHSU, 32'h8765_4321, 32'hFEDC_BA98, 5'd7);
    idle(4);

    // unsupported opcodes retire zero
    op(ADD, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 32'h0);
    op(DIV, 32'hFFFF_FFFF, 32'h0000_0003, 5'd11, 32'h0);
    idle(4);

    // enable stall mid-flight
    mop(MUL, 32'd12345, 32'd678, 5'd12);
    en = 1'b0;
    idle(1);
    chk("stall_busy_1", busy, 1);
    idle(1);
    chk("stall_busy_2", busy, 1);
    en = 1'b1;
    idle(4);

    // enable stall while the completion strobe is up
    mop(MULHU, 32'hCAFE_F00D, 32'h0BAD_CAFE, 5'd13);
    idle(2);
    en = 1'b0;
    idle(2);
    en = 1'b1;
    idle(3);

    // randomised traffic with random stalls
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      ra = $urandom;
      rb = $urandom;
      ro = op_pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) != 0)
        mop(ro, ra, rb, 5'($urandom_range(1, 31)));
      else
        idle(1);
    end
    en = 1'b1;
    idle(4);

    // flush kills in-flight work and a same-cycle start
    mop(MUL, 32'd3, 32'd5, 5'd20);
    mop(MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd21);
    flush = 1'b1;
    mop(MUL, 32'd9, 32'd9, 5'd22);
    flush = 1'b0;
    idle(4);

    // flush while stalled
    mop(MULHU, 32'd77, 32'd88, 5'd23);
    en    = 1'b0;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    en    = 1'b1;
    idle(4);

    // asynchronous reset mid-flight
    mop(MUL, 32'd11, 32'd13, 5'd24);
    mop(MUL, 32'd17, 32'd19, 5'd25);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_p_last", p_last, 0);
    chk("midrst_result", result, 0);
    chk("midrst_uu_rd", uu_rd, 0);
    chk("midrst_o_sig", o_sig, 0);
    chk("midrst_busy", busy, 0);
    q.delete();
    exp_plast = 1'b0;
    last_res  = '0;
    last_sb   = '0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(5);

    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_mul_pipe.md
INT_MUL_PIPE -- requirements
Module: int_mul_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  XLEN  32  operand and result width; SHALL be even and at least 8.
  STAGES  3  operation latency in enabled cycles; SHALL be at least 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state is on the rising edge.
  reset_n  in  1  asynchronous active-low reset.
  en  in  1  pipeline advance; when 0, all pipeline state holds.
  flush  in  1  kills every in-flight operation.
  p_start  in  1  operation valid at input.
  i_pipelined_signals  in  exe_p_mux_bus_type  sideband carried with the operation.
  rs1, rs2  in  XLEN each  operands.
  alu_op  in  alu_t  MUL, MULH, MULHSU or MULHU.
  chk_rd  in  5  register index for the hazard query.
  o_pipelined_signals  out  exe_p_mux_bus_type  sideband of the completing operation.
  uu_rd  out  5  rd of the completing operation.
  p_last  out  1  completion strobe; result is valid this cycle.
  result  out  XLEN  registered result.
  busy  out  1  at least one valid operation is in flight.
  rd_hit  out  1  a valid in-flight operation has rd equal to chk_rd and chk_rd is not 0.

Function
REQ-003 An operation SHALL be accepted when p_start=1, en=1 and flush=0 on a rising edge.
REQ-004 p_last SHALL be 1 after exactly STAGES further edges with en=1 following acceptance. Edges with en=0 SHALL NOT count.
REQ-005 Throughput SHALL be one accepted operation per enabled cycle. There SHALL be no structural stalls.
REQ-006 Each operand SHALL be extended to XLEN+1 bits:
  MUL, MULH: both operands signed.
  MULHSU: rs1 signed, rs2 zero-extended.
  MULHU: both operands zero-extended.
  The product SHALL be formed signed at 2*XLEN+2 bits.
REQ-007 result SHALL be product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-008 An unsupported alu_op SHALL still propagate with valid timing and SHALL produce result 0.
REQ-009 rs1, rs2, alu_op, rd and i_pipelined_signals SHALL be registered in stage 1.
  The product MAY be retimed across stages 2..STAGES.
  When STAGES=1, stage 1 SHALL also be the output register.
REQ-010 uu_rd, o_pipelined_signals and result SHALL update only on a completing edge. They SHALL otherwise hold their last values.
REQ-011 p_last SHALL be a one-cycle strobe per operation while en=1. When en=0, p_last and all outputs SHALL hold.
REQ-012 flush=1 SHALL clear every stage valid bit and p_last on the next edge, regardless of en.
  A p_start in the same cycle as flush SHALL be discarded (flush wins).
  Data registers need not be cleared.
REQ-013 busy SHALL be the combinational OR of the stage valid bits, excluding the output strobe.
REQ-014 rd_hit SHALL be combinational over the valid stages and SHALL include the completing stage while p_last=1.
REQ-015 Signed overflow SHALL wrap per RISC-V semantics. No exception signalling SHALL exist.

Reset
REQ-016 While reset_n=0, all of the following SHALL be 0 asynchronously: valid bits, p_last, uu_rd, o_pipelined_signals, result, and stage data registers (alu_op reset value alu_t'(0)).
REQ-017 Reset asserted mid-operation SHALL discard all in-flight work. No p_last SHALL appear after release until a new acceptance.
REQ-018 Release of reset SHALL need no synchronisation beyond the codebase's reset synchroniser.

Structure
REQ-019 alu_t and exe_p_mux_bus_type SHALL remain in riscv_types. No new package types are required.
REQ-020 The MUL_OPS set, the sign-extension control and the valid/data stage register SHALL be local to the module.
REQ-021 The signed (XLEN+1)x(XLEN+1) multiplier SHALL be one sub-module, int_mul_prod. It SHALL be combinational and width-parametrised, so it can be replaced by a technology macro.

Verification (XLEN=32, STAGES=3)
REQ-022 MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL with the same operands -> 0x00000000. p_last 3 cycles after acceptance.
REQ-023 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with the same operands -> 0xFFFFFFFF. MUL 7 x -3 -> 0xFFFFFFEB.
REQ-024 Back-to-back accepts at cycles 0,1,2 with rd 5,6,7 -> p_last at cycles 3,4,5 with uu_rd 5,6,7 in order.
  With chk_rd=6 at cycle 2 -> rd_hit=1. With chk_rd=0 -> rd_hit=0.
REQ-025 Accept at cycle 0, en=0 during cycles 1-2 -> p_last at cycle 5, result unchanged, busy=1 throughout the stall.
REQ-026 Two ops in flight, then flush=1 with p_start=1 -> no p_last afterwards, busy=0 next cycle.
  Reset asserted mid-flight -> all outputs 0 immediately and no stale p_last after release.
